// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, size encodings and strobe masks for the memory access controller
package mem_pkg;

  localparam int unsigned TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic [7:0] STRB_BYTE   = 8'h01;
  localparam logic [7:0] STRB_HALF   = 8'h03;
  localparam logic [7:0] STRB_WORD   = 8'h0F;
  localparam logic [7:0] STRB_DOUBLE = 8'hFF;

  function automatic logic [7:0] size_mask(size_e s);
    case (s)
      SZ_BYTE: return STRB_BYTE;
      SZ_HALF: return STRB_HALF;
      SZ_WORD: return STRB_WORD;
      default: return STRB_DOUBLE;
    endcase
  endfunction

  function automatic logic misaligned(size_e s, logic [2:0] off);
    case (s)
      SZ_HALF:   return off[0];
      SZ_WORD:   return |off[1:0];
      SZ_DOUBLE: return |off;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts the addressed lanes of a 64-bit read and sign/zero-extends them
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  offset_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [63:0] data_o
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    data_o  = shifted;
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SZ_HALF: data_o = unsigned_i ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SZ_WORD: data_o = unsigned_i ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store controller driving a request/grant/response data bus
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = mem_pkg::TIMEOUT_CYC
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        mem_v_i,
  input  logic        mem_load_i,
  input  logic        mem_store_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [63:0] mem_addr_i,
  input  logic [63:0] mem_wdata_i,
  input  logic        wb_stall_i,
  output logic        mem_stall_o,
  output logic        mem_done_o,
  output logic [63:0] mem_result_o,
  output logic        mem_lam_o,
  output logic        mem_laf_o,
  output logic        mem_sam_o,
  output logic        mem_saf_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  output logic [7:0]  dmem_wstrb_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic        dmem_err_i,
  input  logic [63:0] dmem_rdata_i
);
  import mem_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
  size_e       size_q, size_d;
  logic        store_q, store_d, uns_q, uns_d;
  logic        lam_q, lam_d, sam_q, sam_d, laf_q, laf_d, saf_q, saf_d;
  logic        stall, in_req, in_done, start;
  logic [63:0] load_data, wdata_rep;

  load_align u_load_align (
    .rdata_i    (dmem_rdata_i),
    .offset_i   (addr_q[2:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  assign start = mem_v_i && (mem_load_i || mem_store_i);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    store_d  = store_q;
    uns_d    = uns_q;
    result_d = result_q;
    lam_d    = lam_q;
    sam_d    = sam_q;
    laf_d    = laf_q;
    saf_d    = saf_q;
    stall    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          stall    = 1'b1;
          addr_d   = mem_addr_i;
          wdata_d  = mem_wdata_i;
          size_d   = size_e'(mem_size_i);
          store_d  = mem_store_i;
          uns_d    = mem_unsigned_i;
          result_d = '0;
          cnt_d    = '0;
          laf_d    = 1'b0;
          saf_d    = 1'b0;
          lam_d    = 1'b0;
          sam_d    = 1'b0;
          // Misaligned accesses never reach the bus; report the fault directly.
          if (misaligned(size_e'(mem_size_i), mem_addr_i[2:0])) begin
            lam_d   = !mem_store_i;
            sam_d   = mem_store_i;
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (dmem_gnt_i) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (dmem_rvalid_i) begin
          state_d = ST_DONE;
          if (dmem_err_i) begin
            laf_d = !store_q;
            saf_d = store_q;
          end else if (!store_q) begin
            result_d = load_data;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          laf_d   = !store_q;
          saf_d   = store_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (!wb_stall_i) state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wdata_rep = wdata_q;
    case (size_q)
      SZ_BYTE: wdata_rep = {8{wdata_q[7:0]}};
      SZ_HALF: wdata_rep = {4{wdata_q[15:0]}};
      SZ_WORD: wdata_rep = {2{wdata_q[31:0]}};
      default: wdata_rep = wdata_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= SZ_BYTE;
      store_q  <= 1'b0;
      uns_q    <= 1'b0;
      result_q <= '0;
      lam_q    <= 1'b0;
      sam_q    <= 1'b0;
      laf_q    <= 1'b0;
      saf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      store_q  <= store_d;
      uns_q    <= uns_d;
      result_q <= result_d;
      lam_q    <= lam_d;
      sam_q    <= sam_d;
      laf_q    <= laf_d;
      saf_q    <= saf_d;
    end
  end

  // Bus and result outputs are qualified by state so nothing stale leaks outside REQ/DONE.
  assign in_req       = (state_q == ST_REQ);
  assign in_done      = (state_q == ST_DONE);
  assign mem_stall_o  = stall && reset_n_i;
  assign mem_done_o   = in_done;
  assign mem_result_o = in_done ? result_q : '0;
  assign mem_lam_o    = in_done && lam_q;
  assign mem_sam_o    = in_done && sam_q;
  assign mem_laf_o    = in_done && laf_q;
  assign mem_saf_o    = in_done && saf_q;
  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req && store_q;
  assign dmem_addr_o  = in_req ? {addr_q[63:3], 3'b000} : '0;
  assign dmem_wstrb_o = (in_req && store_q) ? (size_mask(size_q) << addr_q[2:0]) : '0;
  assign dmem_wdata_o = (in_req && store_q) ? wdata_rep : '0;

endmodule
